// File: rtl/cache_debug_loader.sv
// Host-side debug master for the instruction and data cache debug ports.
// It turns host bursts into one-word-per-beat accesses and owns the core reset line.
module cache_debug_loader #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_sel,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [3:0]  cmd_be,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        err,
    output logic        busy,
    output logic        core_rst,
    output logic [31:0] inst_a2,
    output logic [31:0] inst_wd2,
    output logic [3:0]  inst_we2,
    input  logic [31:0] inst_rd2,
    output logic [31:0] data_a2,
    output logic [31:0] data_wd2,
    output logic [3:0]  data_we2,
    input  logic [31:0] data_rd2
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_BEAT  = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_WAIT  = 3'd3;
    localparam logic [2:0] RD_RESP  = 3'd4;
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       lat_q, lat_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic             core_rst_q, core_rst_d;
    // Index 0 is the instruction cache, index 1 the data cache.
    logic [1:0][31:0] a2_q, a2_d;
    logic [1:0][31:0] wd2_q, wd2_d;
    logic [1:0][3:0]  we2_q, we2_d;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        be_d       = be_q;
        lat_d      = lat_q;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;
        core_rst_d = core_rst_q;
        a2_d       = a2_q;
        wd2_d      = wd2_q;
        we2_d      = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b10: core_rst_d = 1'b0;
                        2'b11: core_rst_d = 1'b1;
                        2'b00: begin
                            // Instruction memory may only be rewritten while the core is held.
                            if (!cmd_sel && !core_rst_q) begin
                                err_d = 1'b1;
                            end else begin
                                sel_d   = cmd_sel;
                                addr_d  = cmd_addr & ~32'h3;
                                len_d   = cmd_len;
                                be_d    = cmd_be;
                                cnt_d   = 8'd0;
                                state_d = WR_BEAT;
                            end
                        end
                        default: begin
                            sel_d   = cmd_sel;
                            addr_d  = cmd_addr & ~32'h3;
                            len_d   = cmd_len;
                            be_d    = cmd_be;
                            cnt_d   = 8'd0;
                            // a2 is registered on entry so it is valid during RD_ISSUE.
                            a2_d[cmd_sel] = cmd_addr & ~32'h3;
                            state_d = RD_ISSUE;
                        end
                    endcase
                end
            end
            WR_BEAT: begin
                if (wd_valid) begin
                    a2_d[sel_q]  = addr_q;
                    wd2_d[sel_q] = wd_data;
                    we2_d[sel_q] = be_q;
                    addr_d       = addr_q + 32'd4;
                    if (cnt_q == len_q) begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RD_ISSUE: begin
                lat_d   = 3'd0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    rd_data_d = sel_q ? data_rd2 : inst_rd2;
                    state_d   = RD_RESP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RD_RESP: begin
                if (rd_ready) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d        = cnt_q + 8'd1;
                        addr_d       = addr_q + 32'd4;
                        a2_d[sel_q]  = addr_q + 32'd4;
                        state_d      = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            be_q       <= '0;
            lat_q      <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
            a2_q       <= '0;
            wd2_q      <= '0;
            we2_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            be_q       <= be_d;
            lat_q      <= lat_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
            a2_q       <= a2_d;
            wd2_q      <= wd2_d;
            we2_q      <= we2_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wd_ready  = (state_q == WR_BEAT);
    assign rd_valid  = (state_q == RD_RESP);
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign core_rst  = core_rst_q;
    assign inst_a2   = a2_q[0];
    assign inst_wd2  = wd2_q[0];
    assign inst_we2  = we2_q[0];
    assign data_a2   = a2_q[1];
    assign data_wd2  = wd2_q[1];
    assign data_we2  = we2_q[1];
endmodule

// File: tb/tb_cache_debug_loader.sv
// Bench for cache_debug_loader: behavioural cache memories plus an expected-contents
// model, driven by directed scenarios and randomized bursts.
module tb_cache_debug_loader;
    localparam int RL = 1;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_sel = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_be = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        err, busy, core_rst;
    logic [31:0] inst_a2, inst_wd2, inst_rd2;
    logic [3:0]  inst_we2;
    logic [31:0] data_a2, data_wd2, data_rd2;
    logic [3:0]  data_we2;

    int checks = 0;
    int errors = 0;

    // Cache contents as the core would see them, and the expected contents.
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic [31:0] model [2][1024];
    int inst_we_cnt = 0;
    int data_we_cnt = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    cache_debug_loader #(.READ_LATENCY(RL)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .err(err), .busy(busy), .core_rst(core_rst),
        .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2), .inst_rd2(inst_rd2),
        .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2)
    );

    // Latency-1 synchronous caches with byte write enables.
    always @(posedge CPU_CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (inst_we2[b]) imem[inst_a2[11:2]][8*b +: 8] <= inst_wd2[8*b +: 8];
            if (data_we2[b]) dmem[data_a2[11:2]][8*b +: 8] <= data_wd2[8*b +: 8];
        end
        inst_rd2 <= imem[inst_a2[11:2]];
        data_rd2 <= dmem[data_a2[11:2]];
        if (inst_we2 != 4'h0) inst_we_cnt <= inst_we_cnt + 1;
        if (data_we2 != 4'h0) data_we_cnt <= data_we_cnt + 1;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic sel, input logic [31:0] addr,
                         input logic [7:0] len, input logic [3:0] be, output logic acc);
        cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_len = len; cmd_be = be;
        cmd_valid = 1'b1;
        acc = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rd(output int n);
        n = 0;
        while (rd_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        CPU_RST = 1'b0;
        repeat (2) tick();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b exp 1", core_rst); end
        checks++; if (inst_we2 !== 4'h0 || data_we2 !== 4'h0) begin errors++; $display("FAIL reset_we2 got %h/%h exp 0/0", inst_we2, data_we2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (inst_a2 !== 32'h0 || data_a2 !== 32'h0 || rd_data !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_regs got a2 %h/%h rd %h err %b exp zeros", inst_a2, data_a2, rd_data, err); end
        CPU_RST = 1'b1;
        tick();
        $display("reset: core_rst=%b busy=%b cmd_ready=%b", core_rst, busy, cmd_ready);
    endtask

    task automatic test_inst_load();
        logic acc;
        int n;
        logic [31:0] w [4];
        w[0] = 32'h00000013; w[1] = 32'h00100093; w[2] = 32'h00200113; w[3] = 32'h00308193;
        issue(2'b11, 1'b0, 32'h0, 8'd0, 4'h0, acc);
        checks++; if (acc !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL halt got acc %b core_rst %b exp 1 1", acc, core_rst); end
        issue(2'b00, 1'b0, 32'h00000003, 8'd3, 4'hF, acc);
        checks++; if (acc !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL iload_accept got acc %b busy %b exp 1 1", acc, busy); end
        wd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wd_data = w[i];
            checks++; if (wd_ready !== 1'b1) begin errors++; $display("FAIL iload_wd_ready beat %0d got %b exp 1", i, wd_ready); end
            tick();
            checks++;
            if (inst_we2 !== 4'hF || inst_a2 !== 32'(4 * i) || inst_wd2 !== w[i] || data_we2 !== 4'h0) begin
                errors++;
                $display("FAIL iload_beat%0d got we %h a2 %h wd %h dwe %h exp we f a2 %h wd %h dwe 0",
                         i, inst_we2, inst_a2, inst_wd2, data_we2, 32'(4 * i), w[i]);
            end
            model[0][i] = merge(model[0][i], w[i], 4'hF);
            $display("iload beat %0d: a2=%h wd2=%h we2=%h", i, inst_a2, inst_wd2, inst_we2);
        end
        wd_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || inst_we2 !== 4'h0) begin errors++; $display("FAIL iload_end got busy %b we %h exp 0 0", busy, inst_we2); end
        issue(2'b01, 1'b0, 32'h0, 8'd3, 4'h0, acc);
        checks++; if (acc !== 1'b1 || inst_a2 !== 32'h0) begin errors++; $display("FAIL iread_issue got acc %b a2 %h exp 1 0", acc, inst_a2); end
        for (int i = 0; i < 4; i++) begin
            wait_rd(n);
            checks++; if (n != RL + 1) begin errors++; $display("FAIL iread_latency beat %0d got %0d exp %0d", i, n, RL + 1); end
            checks++; if (rd_data !== model[0][i]) begin errors++; $display("FAIL iread_data beat %0d got %h exp %h", i, rd_data, model[0][i]); end
            $display("iread beat %0d: rd_data=%h", i, rd_data);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iread_end got busy %b exp 0", busy); end
    endtask

    task automatic test_data_read_stall();
        logic acc;
        int n;
        logic [31:0] w [2];
        w[0] = 32'hDEADBEEF; w[1] = 32'h12345678;
        issue(2'b00, 1'b1, 32'h100, 8'd1, 4'hF, acc);
        wd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wd_data = w[i];
            tick();
            model[1][(32'h100 >> 2) + i] = w[i];
        end
        wd_valid = 1'b0;
        tick();
        issue(2'b01, 1'b1, 32'h100, 8'd1, 4'h0, acc);
        checks++; if (acc !== 1'b1 || data_a2 !== 32'h100) begin errors++; $display("FAIL dread_issue got acc %b a2 %h exp 1 100", acc, data_a2); end
        wait_rd(n);
        checks++; if (n != RL + 1) begin errors++; $display("FAIL dread_latency got %0d exp %0d", n, RL + 1); end
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model[1][64]) begin
                errors++; $display("FAIL dread_stall%0d got valid %b data %h exp 1 %h", s, rd_valid, rd_data, model[1][64]);
            end
        end
        $display("dread beat 0: rd_data=%h after 3 stall cycles", rd_data);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_rd(n);
        checks++; if (n != RL + 1 || rd_data !== model[1][65]) begin
            errors++; $display("FAIL dread_beat1 got lat %0d data %h exp %0d %h", n, rd_data, RL + 1, model[1][65]); end
        $display("dread beat 1: rd_data=%h", rd_data);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dread_end got busy %b exp 0", busy); end
    endtask

    task automatic test_reject_wrap();
        logic acc;
        int n;
        int pre;
        logic [31:0] w [2];
        w[0] = $urandom; w[1] = $urandom;
        issue(2'b10, 1'b0, 32'h0, 8'd0, 4'h0, acc);
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL run got core_rst %b exp 0", core_rst); end
        pre = inst_we_cnt;
        wd_valid = 1'b1;
        wd_data = 32'hBAD0BAD0;
        issue(2'b00, 1'b0, 32'h40, 8'd0, 4'hF, acc);
        checks++; if (acc !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reject_pulse got acc %b err %b busy %b exp 1 1 0", acc, err, busy); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reject_single got err %b exp 0", err); end
        repeat (3) tick();
        wd_valid = 1'b0;
        checks++; if (inst_we_cnt != pre) begin errors++; $display("FAIL reject_no_write got %0d exp %0d", inst_we_cnt - pre, 0); end
        $display("reject: err pulsed, inst writes=%0d", inst_we_cnt - pre);
        issue(2'b00, 1'b1, 32'hFFFFFFFC, 8'd1, 4'hF, acc);
        checks++; if (acc !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wrap_accept got acc %b busy %b exp 1 1", acc, busy); end
        wd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ea;
            ea = 32'hFFFFFFFC + 32'(4 * i);
            wd_data = w[i];
            tick();
            checks++; if (data_we2 !== 4'hF || data_a2 !== ea || data_wd2 !== w[i]) begin
                errors++; $display("FAIL wrap_beat%0d got we %h a2 %h wd %h exp f %h %h", i, data_we2, data_a2, data_wd2, ea, w[i]); end
            model[1][ea[11:2]] = w[i];
            $display("wrap beat %0d: a2=%h", i, data_a2);
        end
        wd_valid = 1'b0;
        tick();
        issue(2'b01, 1'b1, 32'hFFFFFFFE, 8'd1, 4'h0, acc);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ea;
            ea = 32'hFFFFFFFC + 32'(4 * i);
            wait_rd(n);
            checks++; if (rd_valid !== 1'b1 || rd_data !== model[1][ea[11:2]] || data_a2 !== ea) begin
                errors++; $display("FAIL wrap_read%0d got data %h a2 %h exp %h %h", i, rd_data, data_a2, model[1][ea[11:2]], ea); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic acc;
        int pre;
        issue(2'b00, 1'b1, 32'h200, 8'd7, 4'hF, acc);
        wd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wd_data = $urandom;
            model[1][(32'h200 >> 2) + i] = wd_data;
            tick();
        end
        CPU_RST = 1'b0;
        tick();
        checks++; if (data_we2 !== 4'h0 || busy !== 1'b0 || core_rst !== 1'b1 || data_a2 !== 32'h0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midreset got we %h busy %b core_rst %b a2 %h ready %b exp 0 0 1 0 1",
                               data_we2, busy, core_rst, data_a2, cmd_ready); end
        CPU_RST = 1'b1;
        pre = data_we_cnt;
        repeat (5) tick();
        wd_valid = 1'b0;
        checks++; if (data_we_cnt != pre || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_abandon got writes %0d busy %b exp 0 0", data_we_cnt - pre, busy); end
        $display("midreset: burst abandoned, writes after release=%0d", data_we_cnt - pre);
    endtask

    task automatic test_random_bursts();
        logic acc;
        int n;
        logic [31:0] d [8];
        for (int it = 0; it < 6; it++) begin
            logic        sel;
            logic [31:0] base;
            logic [7:0]  len;
            sel  = 1'($urandom);
            base = $urandom;
            len  = 8'($urandom_range(0, 5));
            for (int p = 0; p < 2; p++) begin
                logic [3:0] be;
                int beat;
                int cyc;
                be = (p == 0) ? 4'hF : 4'($urandom);
                for (int i = 0; i < 8; i++) d[i] = $urandom;
                issue(2'b00, sel, base, len, be, acc);
                checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rnd%0d_accept got %b exp 1", it, acc); end
                beat = 0;
                cyc = 0;
                while (beat <= int'(len) && cyc < 300) begin
                    logic hs;
                    logic [31:0] ea;
                    logic [3:0]  swe, owe;
                    wd_valid = ($urandom_range(0, 2) != 0);
                    wd_data  = d[beat];
                    hs = wd_valid;
                    if (wd_ready !== 1'b1) begin checks++; errors++; $display("FAIL rnd%0d_wd_ready got %b exp 1", it, wd_ready); end
                    tick();
                    cyc++;
                    swe = sel ? data_we2 : inst_we2;
                    owe = sel ? inst_we2 : data_we2;
                    ea  = (base & ~32'h3) + 32'(4 * beat);
                    checks++;
                    if (hs) begin
                        if (swe !== be || owe !== 4'h0 || (sel ? data_a2 : inst_a2) !== ea || (sel ? data_wd2 : inst_wd2) !== d[beat]) begin
                            errors++; $display("FAIL rnd%0d_wbeat%0d got we %h/%h a2 %h exp %h/0 %h", it, beat, swe, owe,
                                               sel ? data_a2 : inst_a2, be, ea);
                        end
                        model[sel][ea[11:2]] = merge(model[sel][ea[11:2]], d[beat], be);
                        beat++;
                    end else if (swe !== 4'h0 || owe !== 4'h0) begin
                        errors++; $display("FAIL rnd%0d_idle_we got %h/%h exp 0/0", it, swe, owe);
                    end
                end
                wd_valid = 1'b0;
                checks++; if (beat <= int'(len)) begin errors++; $display("FAIL rnd%0d_wtimeout got %0d beats exp %0d", it, beat, len + 1); end
                tick();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_wbusy got %b exp 0", it, busy); end
            end
            issue(2'b01, sel, base, len, 4'h0, acc);
            for (int i = 0; i <= int'(len); i++) begin
                logic [31:0] ea;
                ea = (base & ~32'h3) + 32'(4 * i);
                wait_rd(n);
                checks++; if (n != RL + 1 || rd_data !== model[sel][ea[11:2]]) begin
                    errors++; $display("FAIL rnd%0d_rbeat%0d got lat %0d data %h exp %0d %h", it, i, n, rd_data, RL + 1, model[sel][ea[11:2]]); end
                repeat ($urandom_range(0, 2)) tick();
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_rbusy got %b exp 0", it, busy); end
            $display("random burst %0d: sel=%0d base=%h len=%0d", it, sel, base & ~32'h3, len);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            model[0][i] = 32'h0;
            model[1][i] = 32'h0;
        end
        test_reset();
        test_inst_load();
        test_data_read_stall();
        test_reject_wrap();
        test_reset_mid_burst();
        test_random_bursts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
